pipeline_stall_ctrl: RTL and testbench
======================================

PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 SHALL: clk  input  1  pipeline clock; all state changes on rising edge.
REQ-002 SHALL: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL: hazard  input  1  load-use stall request from the hazard detector.
REQ-004 SHALL: icache_resp  input  1  fetch completes this cycle; a fetch is requested every cycle.
REQ-005 SHALL: dcache_req  input  1  MEM-stage read or write in progress.
REQ-006 SHALL: dcache_resp  input  1  data access completes this cycle.
REQ-007 SHALL: branch_taken  input  1  MEM stage resolved a taken branch or jump.
REQ-008 SHALL: load_pc  output  1  PC register load enable.
REQ-009 SHALL: pc_sel_target  output  1  PC mux selects the latched redirect target.
REQ-010 SHALL: load_target  output  1  datapath latches the branch target from MEM.
REQ-011 SHALL: load_if_id  output  1  IF_ID load enable.
REQ-012 SHALL: flush_if_id  output  1  IF_ID loads a NOP.
REQ-013 SHALL: load_id_ex  output  1  ID_EX load enable.
REQ-014 SHALL: bubble_id_ex  output  1  ID_EX loads zeroed control.
REQ-015 SHALL: load_ex_mem  output  1  EX_MEM load enable.
REQ-016 SHALL: bubble_ex_mem  output  1  EX_MEM loads zeroed control.
REQ-017 SHALL: bubble_mem_wb  output  1  MEM_WB (always loading) loads zeroed control.
REQ-018 SHALL: stall_cycles  output  16  saturating count of cycles with load_pc=0.
REQ-019 SHALL: flush_count  output  8  wrapping count of redirects.

Function
REQ-020 SHALL: two-state FSM, RUN and REDIR_WAIT; all control outputs combinational from state and inputs (zero latency); default 0 except where stated.
REQ-021 SHALL: dstall = dcache_req & ~dcache_resp; when set, in any state: load_pc, load_if_id, load_id_ex, load_ex_mem = 0; bubble_mem_wb = 1; all else 0; state held; branch_taken, hazard ignored.
REQ-022 SHALL: RUN, no dstall, branch_taken: load_target = 1, flush_if_id = 1, load_if_id = 1, load_id_ex = 1, bubble_id_ex = 1, load_ex_mem = 1, bubble_ex_mem = 1.
REQ-023 SHALL: in REQ-022 case with icache_resp = 1: load_pc = 1, pc_sel_target = 1, stay RUN; with icache_resp = 0: load_pc = 0, go to REDIR_WAIT.
REQ-024 SHALL: RUN, no dstall, no branch, hazard or ~icache_resp: load_pc = 0, load_if_id = 0, load_id_ex = 1, bubble_id_ex = 1, load_ex_mem = 1.
REQ-025 SHALL: RUN, no dstall, no branch, no hazard, icache_resp: load_pc, load_if_id, load_id_ex, load_ex_mem = 1, no bubbles, pc_sel_target = 0.
REQ-026 SHALL: REDIR_WAIT, no dstall: load_if_id = 1, flush_if_id = 1, load_id_ex = 1, bubble_id_ex = 1, load_ex_mem = 1; hazard and branch_taken ignored.
REQ-027 SHALL: REDIR_WAIT with icache_resp = 1: load_pc = 1, pc_sel_target = 1, next state RUN; else load_pc = 0, stay.
REQ-028 SHALL: stall_cycles increments each cycle load_pc = 0, holds at 0xFFFF.
REQ-029 SHALL: flush_count increments each cycle load_target = 1, wraps 0xFF -> 0x00.

Reset
REQ-030 SHALL: reset_n = 0 immediately forces state RUN, stall_cycles = 0, flush_count = 0, all control outputs 0, regardless of clk.
REQ-031 SHALL: reset asserted in REDIR_WAIT discards the pending redirect; first cycle after release behaves per REQ-025/REQ-024.

Verification
REQ-032 SHALL: hazard = 1 one cycle, icache_resp = 1 -> load_pc = 0, load_if_id = 0, bubble_id_ex = 1 that cycle; stall_cycles 0 -> 1.
REQ-033 SHALL: dcache_req = 1, dcache_resp = 0 for 3 cycles, hazard = 1 and branch_taken = 1 -> all stage loads 0, bubble_mem_wb = 1 for 3 cycles, flush_count unchanged, stall_cycles = 3.
REQ-034 SHALL: branch_taken = 1 with icache_resp = 0 for 2 further cycles -> load_target = 1 once, REDIR_WAIT entered, load_pc = 1 with pc_sel_target = 1 on icache_resp cycle, flush_count = 1.
REQ-035 SHALL: branch_taken = 1 and icache_resp = 1 same cycle -> load_pc = 1, pc_sel_target = 1, all three flush/bubble outputs 1, state stays RUN.
REQ-036 SHALL: reset_n pulsed low mid-REDIR_WAIT -> counters 0, state RUN, next icache_resp = 1 cycle gives pc_sel_target = 0.
REQ-037 SHALL: stall_cycles preloaded to 0xFFFE by 2 more stalls -> reads 0xFFFF, stays 0xFFFF.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_stall_ctrl
// Purpose  : Stall, flush and bubble control for a five-stage pipeline with
//            redirect handling across instruction-cache misses.
// Revision : 1.0
// ============================================================================
module pipeline_stall_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hazard,
  input  logic        icache_resp,
  input  logic        dcache_req,
  input  logic        dcache_resp,
  input  logic        branch_taken,
  output logic        load_pc,
  output logic        pc_sel_target,
  output logic        load_target,
  output logic        load_if_id,
  output logic        flush_if_id,
  output logic        load_id_ex,
  output logic        bubble_id_ex,
  output logic        load_ex_mem,
  output logic        bubble_ex_mem,
  output logic        bubble_mem_wb,
  output logic [15:0] stall_cycles,
  output logic [7:0]  flush_count
);

  localparam logic [0:0] ST_RUN        = 1'b0;
  localparam logic [0:0] ST_REDIR_WAIT = 1'b1;

  localparam logic [15:0] STALL_MAX = 16'hFFFF;

  logic [0:0]  state_q;
  logic [0:0]  state_d;
  logic [15:0] stall_cycles_q;
  logic [15:0] stall_cycles_d;
  logic [7:0]  flush_count_q;
  logic [7:0]  flush_count_d;
  logic        w_dstall;

  assign w_dstall = dcache_req & ~dcache_resp;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!w_dstall) begin
      case (state_q)
        ST_RUN: begin
          if (branch_taken && !icache_resp) begin
            state_d = ST_REDIR_WAIT;
          end
        end
        ST_REDIR_WAIT: begin
          if (icache_resp) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Outputs are forced low while reset is asserted, independent of the clock.
  always_comb begin
    load_pc       = 1'b0;
    pc_sel_target = 1'b0;
    load_target   = 1'b0;
    load_if_id    = 1'b0;
    flush_if_id   = 1'b0;
    load_id_ex    = 1'b0;
    bubble_id_ex  = 1'b0;
    load_ex_mem   = 1'b0;
    bubble_ex_mem = 1'b0;
    bubble_mem_wb = 1'b0;
    if (!reset_n) begin
      bubble_mem_wb = 1'b0;
    end else if (w_dstall) begin
      bubble_mem_wb = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (branch_taken) begin
            load_target   = 1'b1;
            load_if_id    = 1'b1;
            flush_if_id   = 1'b1;
            load_id_ex    = 1'b1;
            bubble_id_ex  = 1'b1;
            load_ex_mem   = 1'b1;
            bubble_ex_mem = 1'b1;
            load_pc       = icache_resp;
            pc_sel_target = icache_resp;
          end else if (hazard || !icache_resp) begin
            load_id_ex    = 1'b1;
            bubble_id_ex  = 1'b1;
            load_ex_mem   = 1'b1;
          end else begin
            load_pc       = 1'b1;
            load_if_id    = 1'b1;
            load_id_ex    = 1'b1;
            load_ex_mem   = 1'b1;
          end
        end
        ST_REDIR_WAIT: begin
          // The branch already left MEM, so younger stages only need flushing.
          load_if_id    = 1'b1;
          flush_if_id   = 1'b1;
          load_id_ex    = 1'b1;
          bubble_id_ex  = 1'b1;
          load_ex_mem   = 1'b1;
          load_pc       = icache_resp;
          pc_sel_target = icache_resp;
        end
        default: begin
          bubble_mem_wb = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (!load_pc && (stall_cycles_q != STALL_MAX)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  always_comb begin
    flush_count_d = flush_count_q;
    if (load_target) begin
      flush_count_d = flush_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles_q <= 16'd0;
      flush_count_q  <= 8'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_stall_ctrl
// Purpose  : Vector table, corner sequences and random traffic against a
//            rule-level model of the stall controller.
// Revision : 1.0
// ============================================================================
module tb_pipeline_stall_ctrl;

  logic        clk;
  logic        reset_n;
  logic        hazard;
  logic        icache_resp;
  logic        dcache_req;
  logic        dcache_resp;
  logic        branch_taken;
  logic        load_pc;
  logic        pc_sel_target;
  logic        load_target;
  logic        load_if_id;
  logic        flush_if_id;
  logic        load_id_ex;
  logic        bubble_id_ex;
  logic        load_ex_mem;
  logic        bubble_ex_mem;
  logic        bubble_mem_wb;
  logic [15:0] stall_cycles;
  logic [7:0]  flush_count;

  pipeline_stall_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .hazard       (hazard),
    .icache_resp  (icache_resp),
    .dcache_req   (dcache_req),
    .dcache_resp  (dcache_resp),
    .branch_taken (branch_taken),
    .load_pc      (load_pc),
    .pc_sel_target(pc_sel_target),
    .load_target  (load_target),
    .load_if_id   (load_if_id),
    .flush_if_id  (flush_if_id),
    .load_id_ex   (load_id_ex),
    .bubble_id_ex (bubble_id_ex),
    .load_ex_mem  (load_ex_mem),
    .bubble_ex_mem(bubble_ex_mem),
    .bubble_mem_wb(bubble_mem_wb),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed order: load_pc pc_sel load_target load_if_id flush_if_id
  //               load_id_ex bubble_id_ex load_ex_mem bubble_ex_mem bubble_mem_wb
  logic [9:0] ctrl;
  assign ctrl = {load_pc, pc_sel_target, load_target, load_if_id, flush_if_id,
                 load_id_ex, bubble_id_ex, load_ex_mem, bubble_ex_mem, bubble_mem_wb};

  localparam logic [9:0] C_ADVANCE = 10'b1001010100;
  localparam logic [9:0] C_FRONT   = 10'b0000011100;
  localparam logic [9:0] C_BR_HIT  = 10'b1111111110;
  localparam logic [9:0] C_BR_MISS = 10'b0011111110;
  localparam logic [9:0] C_DSTALL  = 10'b0000000001;

  int checks = 0;
  int errors = 0;

  bit m_redir;
  int m_stall;
  int m_flush;
  logic [9:0] last_ctrl;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Rule-level model: a data stall freezes everything; a redirect (new branch
  // or pending one) flushes the front end; otherwise stall or advance.
  function automatic logic [9:0] model_ctrl(input bit redir, input logic h, input logic ic,
                                            input logic dq, input logic dr, input logic br);
    bit fresh_br;
    if (dq && !dr) return C_DSTALL;
    if (redir || br) begin
      fresh_br = br && !redir;
      return {ic, ic, fresh_br, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, fresh_br, 1'b0};
    end
    if (h || !ic) return C_FRONT;
    return C_ADVANCE;
  endfunction

  // Called at posedge+1; leaves the bench at the following posedge+1.
  task automatic step(input logic h, input logic ic, input logic dq, input logic dr,
                      input logic br, input bit full_check);
    logic [9:0] exp_ctrl;
    hazard = h; icache_resp = ic; dcache_req = dq; dcache_resp = dr; branch_taken = br;
    #3;
    exp_ctrl  = model_ctrl(m_redir, h, ic, dq, dr, br);
    last_ctrl = ctrl;
    if (full_check) check("ctrl", {22'd0, ctrl}, {22'd0, exp_ctrl});
    if (!exp_ctrl[9] && m_stall < 65535) m_stall++;
    if (exp_ctrl[7]) m_flush = (m_flush + 1) % 256;
    if (!(dq && !dr)) m_redir = (m_redir || br) && !ic;
    @(posedge clk);
    #1;
    if (full_check) begin
      check("stall_cycles", {16'd0, stall_cycles}, m_stall);
      check("flush_count", {24'd0, flush_count}, m_flush);
    end
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    hazard = 1'b0; icache_resp = 1'b1; dcache_req = 1'b0; dcache_resp = 1'b0; branch_taken = 1'b1;
    #1;
    check("reset_ctrl", {22'd0, ctrl}, 32'd0);
    check("reset_stall", {16'd0, stall_cycles}, 32'd0);
    check("reset_flush", {24'd0, flush_count}, 32'd0);
    reset_n = 1'b1;
    m_redir = 1'b0; m_stall = 0; m_flush = 0;
  endtask

  typedef struct {
    logic [4:0] in;      // hazard icache_resp dcache_req dcache_resp branch_taken
    logic [9:0] exp_ctrl;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int f0, s0;
    vecs[0] = '{5'b01000, C_ADVANCE};
    vecs[1] = '{5'b11000, C_FRONT};
    vecs[2] = '{5'b00000, C_FRONT};
    vecs[3] = '{5'b01001, C_BR_HIT};
    vecs[4] = '{5'b00001, C_BR_MISS};
    vecs[5] = '{5'b11101, C_DSTALL};
    vecs[6] = '{5'b01110, C_ADVANCE};
    vecs[7] = '{5'b11001, C_BR_HIT};
    vecs[8] = '{5'b00110, C_FRONT};
    vecs[9] = '{5'b10010, C_FRONT};

    reset_n = 1'b0;
    hazard = 1'b0; icache_resp = 1'b0; dcache_req = 1'b0; dcache_resp = 1'b0; branch_taken = 1'b0;
    m_redir = 1'b0; m_stall = 0; m_flush = 0;
    repeat (2) @(posedge clk);
    #1;
    check("init_ctrl", {22'd0, ctrl}, 32'd0);
    check("init_stall", {16'd0, stall_cycles}, 32'd0);
    check("init_flush", {24'd0, flush_count}, 32'd0);
    reset_n = 1'b1;

    // Each vector applied from RUN; a plain fetch cycle afterwards returns to RUN.
    for (int i = 0; i < 10; i++) begin
      step(vecs[i].in[4], vecs[i].in[3], vecs[i].in[2], vecs[i].in[1], vecs[i].in[0], 1'b1);
      check($sformatf("vec%0d", i), {22'd0, last_ctrl}, {22'd0, vecs[i].exp_ctrl});
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // Single hazard cycle
    pulse_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("hazard_bits", {29'd0, last_ctrl[9], last_ctrl[6], last_ctrl[3]}, 32'b001);
    check("hazard_stall", {16'd0, stall_cycles}, 32'd1);

    // Three data-stall cycles override hazard and branch
    s0 = stall_cycles; f0 = flush_count;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      check("dstall_ctrl", {22'd0, last_ctrl}, {22'd0, C_DSTALL});
    end
    check("dstall_cnt", {16'd0, stall_cycles}, s0 + 3);
    check("dstall_flush", {24'd0, flush_count}, f0);

    // Branch while the fetch misses for two further cycles
    pulse_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("redir_lt", {31'd0, last_ctrl[7]}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("redir_wait1", {22'd0, last_ctrl}, 32'b0001111100);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("redir_wait2_lpc", {31'd0, last_ctrl[9]}, 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("redir_done", {22'd0, last_ctrl}, 32'b1101111100);
    check("redir_flush", {24'd0, flush_count}, 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("redir_back_run", {22'd0, last_ctrl}, {22'd0, C_ADVANCE});

    // Branch with fetch hit stays in RUN
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("br_hit", {22'd0, last_ctrl}, {22'd0, C_BR_HIT});
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("br_hit_run", {22'd0, last_ctrl}, {22'd0, C_ADVANCE});

    // Reset inside REDIR_WAIT drops the pending redirect
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    pulse_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_redir_sel", {22'd0, last_ctrl}, {22'd0, C_ADVANCE});

    // Random traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 199) == 0) pulse_reset();
      step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 5) == 0), 1'b1);
    end

    // Saturation of stall_cycles
    pulse_reset();
    for (int i = 0; i < 65534; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sat_pre", {16'd0, stall_cycles}, 32'hFFFE);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("sat_max", {16'd0, stall_cycles}, 32'hFFFF);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("sat_hold", {16'd0, stall_cycles}, 32'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
